// File: rtl/posit_pkg.sv
// Shared constants and width helpers for the posit decode pipeline.
// Latency: none (package only).
// Backpressure: not applicable.
package posit_pkg;

   // Per-lane class encoding on out_class_o
   localparam logic [1:0] CLS_ZERO  = 2'b00;
   localparam logic [1:0] CLS_VALID = 2'b01;
   localparam logic [1:0] CLS_NAR   = 2'b10;

   // Signed regime: magnitude up to WIDTH-2 plus sign bit
   function automatic int regi_w(input int width);
      return $clog2(width) + 1;
   endfunction

   // Fraction bits left after sign, shortest regime (2 bits) and exponent
   function automatic int frac_w(input int width, input int es);
      return width - 3 - es;
   endfunction

   // Signed regime*2^ES + exp
   function automatic int scale_w(input int width, input int es);
      return $clog2(width) + es + 1;
   endfunction

   // Exponent port width; kept at one bit (tied to zero) when ES is 0
   function automatic int exp_w(input int es);
      return (es > 0) ? es : 1;
   endfunction

endpackage

// File: rtl/posit_lane_decode.sv
// Per-lane posit field extractor: regime, exponent, fraction and scale from |p|.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage owns flow control.
// Ports: cls (lane class), a (two's-complement magnitude of p[WIDTH-2:0]),
//        regime/expo/frac/scale (decoded fields, zero unless cls is valid).
module posit_lane_decode
   import posit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ES    = 2,
   localparam int REGI_W  = regi_w(WIDTH),
   localparam int FRAC_W  = frac_w(WIDTH, ES),
   localparam int SCALE_W = scale_w(WIDTH, ES),
   localparam int EXP_W   = exp_w(ES)
)(
   input  logic [1:0]         cls,
   input  logic [WIDTH-2:0]   a,
   output logic [REGI_W-1:0]  regime,
   output logic [EXP_W-1:0]   expo,
   output logic [FRAC_W-1:0]  frac,
   output logic [SCALE_W-1:0] scale
);

   logic [WIDTH-2:0]   run_x;
   logic [WIDTH-2:0]   rest;
   logic [WIDTH-4:0]   fields;
   logic [REGI_W-1:0]  k;
   logic [REGI_W-1:0]  shamt;
   logic [REGI_W-1:0]  regime_raw;
   logic [EXP_W-1:0]   exp_raw;
   logic [FRAC_W-1:0]  frac_raw;
   logic [SCALE_W-1:0] scale_raw;
   logic               is_valid;

   // XOR against the leading bit turns the regime run into leading zeros;
   // bit WIDTH-2 of run_x is always 0, so the LZD count equals the run length.
   assign run_x = a ^ {(WIDTH-1){a[WIDTH-2]}};

   // Leading-zero detect: highest set bit wins, all-zero gives full run
   always_comb begin : lzd
      k = REGI_W'(WIDTH-1);
      for (int i = 0; i <= WIDTH-2; i++) begin
         if (run_x[i]) k = REGI_W'(WIDTH-2-i);
      end
   end

   // Drop the run and its terminator; shifting past the end fills with zeros
   assign shamt  = k + REGI_W'(1);
   assign rest   = a << shamt;
   assign fields = (WIDTH-3)'(rest >> 2);

   assign regime_raw = a[WIDTH-2] ? (k - REGI_W'(1)) : (REGI_W'(0) - k);

   if (ES > 0) begin : g_exp
      assign exp_raw = fields[WIDTH-4 -: EXP_W];
   end else begin : g_noexp
      assign exp_raw = '0;
   end

   assign frac_raw  = fields[FRAC_W-1:0];
   assign scale_raw = (SCALE_W'($signed(regime_raw)) <<< ES) + SCALE_W'(exp_raw);

   assign is_valid = (cls == CLS_VALID);
   assign regime   = is_valid ? regime_raw : '0;
   assign expo     = is_valid ? exp_raw    : '0;
   assign frac     = is_valid ? frac_raw   : '0;
   assign scale    = is_valid ? scale_raw  : '0;

endmodule

// File: rtl/posit_decode_pipe.sv
// Multi-lane posit<WIDTH,ES> decoder with two registered stages (S1: sign/class/|p|, S2: fields).
// Latency: 2 edges from acceptance to out_valid_o; one transaction per cycle throughput.
// Backpressure: valid/ready; a full pipe with out_ready_i low freezes all state and drops in_ready_o.
// Ports: clk_i/rst_i (sync active-high), flush_i, in_valid_i/in_ready_o/in_data_i,
//        out_valid_o/out_ready_i, per-lane out_sign_o, out_class_o, out_regime_o,
//        out_exp_o (zero when ES=0), out_frac_o, out_scale_o.
module posit_decode_pipe
   import posit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ES    = 2,
   parameter int LANES = 2,
   localparam int REGI_W  = regi_w(WIDTH),
   localparam int FRAC_W  = frac_w(WIDTH, ES),
   localparam int SCALE_W = scale_w(WIDTH, ES),
   localparam int EXP_W   = exp_w(ES),
   localparam int AW      = WIDTH - 1
)(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [LANES*WIDTH-1:0]     in_data_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [LANES-1:0]           out_sign_o,
   output logic [2*LANES-1:0]         out_class_o,
   output logic [LANES*REGI_W-1:0]    out_regime_o,
   output logic [LANES*EXP_W-1:0]     out_exp_o,
   output logic [LANES*FRAC_W-1:0]    out_frac_o,
   output logic [LANES*SCALE_W-1:0]   out_scale_o
);

   // Stage-1 combinational inputs
   logic [LANES-1:0]         in_sign;
   logic [2*LANES-1:0]       in_cls;
   logic [LANES*AW-1:0]      in_a;

   // Stage-1 registers
   logic                     s1_v;
   logic [LANES-1:0]         s1_sign;
   logic [2*LANES-1:0]       s1_cls;
   logic [LANES*AW-1:0]      s1_a;

   // Decoder outputs feeding stage 2
   logic [LANES*REGI_W-1:0]  dec_regime;
   logic [LANES*EXP_W-1:0]   dec_exp;
   logic [LANES*FRAC_W-1:0]  dec_frac;
   logic [LANES*SCALE_W-1:0] dec_scale;

   // Stage-2 registers
   logic                     s2_v;
   logic [LANES-1:0]         s2_sign;
   logic [2*LANES-1:0]       s2_cls;
   logic [LANES*REGI_W-1:0]  s2_regime;
   logic [LANES*EXP_W-1:0]   s2_exp;
   logic [LANES*FRAC_W-1:0]  s2_frac;
   logic [LANES*SCALE_W-1:0] s2_scale;

   logic s2_open;
   logic s1_open;
   logic in_fire;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [WIDTH-1:0] p;
      assign p = in_data_i[l*WIDTH +: WIDTH];

      assign in_sign[l]       = p[WIDTH-1];
      assign in_cls[2*l +: 2] = (p == '0)            ? CLS_ZERO :
                                (p[WIDTH-2:0] == '0) ? CLS_NAR  : CLS_VALID;
      assign in_a[l*AW +: AW] = p[WIDTH-1] ? (~p[WIDTH-2:0] + AW'(1)) : p[WIDTH-2:0];

      posit_lane_decode #(
         .WIDTH (WIDTH),
         .ES    (ES)
      ) u_dec (
         .cls    (s1_cls[2*l +: 2]),
         .a      (s1_a[l*AW +: AW]),
         .regime (dec_regime[l*REGI_W +: REGI_W]),
         .expo   (dec_exp[l*EXP_W +: EXP_W]),
         .frac   (dec_frac[l*FRAC_W +: FRAC_W]),
         .scale  (dec_scale[l*SCALE_W +: SCALE_W])
      );
   end

   // A stage can load when empty or when its contents leave this same edge
   assign s2_open    = !s2_v || out_ready_i;
   assign s1_open    = !s1_v || s2_open;
   assign in_ready_o = !rst_i && s1_open;
   // Flush discards the transaction offered alongside it
   assign in_fire    = in_valid_i && in_ready_o && !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_v      <= 1'b0;
         s1_sign   <= '0;
         s1_cls    <= '0;
         s1_a      <= '0;
         s2_v      <= 1'b0;
         s2_sign   <= '0;
         s2_cls    <= '0;
         s2_regime <= '0;
         s2_exp    <= '0;
         s2_frac   <= '0;
         s2_scale  <= '0;
      end else begin
         if (s2_open && s1_v) begin
            s2_sign   <= s1_sign;
            s2_cls    <= s1_cls;
            s2_regime <= dec_regime;
            s2_exp    <= dec_exp;
            s2_frac   <= dec_frac;
            s2_scale  <= dec_scale;
         end
         if (in_fire) begin
            s1_sign <= in_sign;
            s1_cls  <= in_cls;
            s1_a    <= in_a;
         end
         if (flush_i) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
         end else begin
            if (s2_open) s2_v <= s1_v;
            if (s1_open) s1_v <= in_fire;
         end
      end
   end

   assign out_valid_o  = s2_v && !rst_i;
   assign out_sign_o   = s2_sign;
   assign out_class_o  = s2_cls;
   assign out_regime_o = s2_regime;
   assign out_exp_o    = s2_exp;
   assign out_frac_o   = s2_frac;
   assign out_scale_o  = s2_scale;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Directed and swept bench for posit_decode_pipe at WIDTH=8, ES=2, LANES=2.
// Latency: expects outputs two edges after acceptance.
// Backpressure: exercises stalls, flush and mid-stream reset.
module tb_posit_decode_pipe;

   typedef struct packed {
      logic       sign;
      logic [1:0] cls;
      logic [3:0] regime;
      logic [1:0] ex;
      logic [2:0] frac;
      logic [5:0] scale;
   } fld_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_sign;
   logic [3:0]  out_class;
   logic [7:0]  out_regime;
   logic [3:0]  out_exp;
   logic [5:0]  out_frac;
   logic [11:0] out_scale;
   logic [35:0] outs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign outs = {out_sign, out_class, out_regime, out_exp, out_frac, out_scale};

   posit_decode_pipe #(.WIDTH(8), .ES(2), .LANES(2)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_sign_o   (out_sign),
      .out_class_o  (out_class),
      .out_regime_o (out_regime),
      .out_exp_o    (out_exp),
      .out_frac_o   (out_frac),
      .out_scale_o  (out_scale)
   );

   // Reference decode written as a bit walk with integer arithmetic
   function automatic fld_t model(input logic [7:0] p);
      fld_t       f;
      logic [6:0] a;
      logic [4:0] rest;
      int         k;
      int         pos;
      int         r;
      f = '0;
      f.sign = p[7];
      if (p == 8'h00) f.cls = 2'b00;
      else if (p == 8'h80) f.cls = 2'b10;
      else begin
         f.cls = 2'b01;
         a = p[7] ? (7'(~p[6:0]) + 7'd1) : p[6:0];
         k = 1;
         while (k < 7 && a[6-k] == a[6]) k++;
         r = a[6] ? k - 1 : -k;
         pos = 5 - k;
         rest = '0;
         for (int j = 0; j < 5; j++) begin
            if (pos - j >= 0) rest[4-j] = a[pos-j];
         end
         f.regime = 4'(r);
         f.ex     = rest[4:3];
         f.frac   = rest[2:0];
         f.scale  = 6'(r * 4 + int'(rest[4:3]));
      end
      return f;
   endfunction

   function automatic logic [35:0] pack2(input fld_t l0, input fld_t l1);
      return {l1.sign, l0.sign, l1.cls, l0.cls, l1.regime, l0.regime,
              l1.ex, l0.ex, l1.frac, l0.frac, l1.scale, l0.scale};
   endfunction

   function automatic logic [35:0] model2(input logic [15:0] d);
      return pack2(model(d[7:0]), model(d[15:8]));
   endfunction

   // Offers one transaction to an empty pipe and samples out_valid after each edge
   task automatic run_pair(input logic [15:0] d, output logic [35:0] o,
                           output logic v1, output logic v2);
      in_valid = 1'b1; in_data = d; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      v1 = out_valid;
      @(posedge clk); #1;
      v2 = out_valid;
      o = outs;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
      checks++; if (outs !== 36'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", outs); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: in_ready got %b expected 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [35:0] o;
      logic v1, v2;
      fld_t e0, e1;
      e0 = '{1'b0, 2'b01, 4'd0, 2'd0, 3'b000, 6'd0};
      e1 = '{1'b0, 2'b01, 4'd0, 2'd2, 3'b010, 6'd2};
      run_pair(16'h5240, o, v1, v2);
      checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL basic_lat1: out_valid got %b expected 0", v1); end
      checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL basic_lat2: out_valid got %b expected 1", v2); end
      checks++; if (o !== pack2(e0, e1)) begin errors++; $display("FAIL basic_fields: got %h expected %h", o, pack2(e0, e1)); end
   endtask

   task automatic test_extremes();
      logic [35:0] o;
      logic v1, v2;
      fld_t e0, e1;
      e0 = '{1'b0, 2'b01, 4'd6, 2'd0, 3'b000, 6'd24};
      e1 = '{1'b0, 2'b01, 4'b1010, 2'd0, 3'b000, 6'b101000};
      run_pair(16'h017F, o, v1, v2);
      checks++; if (v2 !== 1'b1 || o !== pack2(e0, e1)) begin errors++; $display("FAIL extremes: got %h/%b expected %h/1", o, v2, pack2(e0, e1)); end
      e0 = '{1'b0, 2'b00, 4'd0, 2'd0, 3'b000, 6'd0};
      e1 = '{1'b1, 2'b10, 4'd0, 2'd0, 3'b000, 6'd0};
      run_pair(16'h8000, o, v1, v2);
      checks++; if (v2 !== 1'b1 || o !== pack2(e0, e1)) begin errors++; $display("FAIL specials: got %h/%b expected %h/1", o, v2, pack2(e0, e1)); end
   endtask

   task automatic test_negatives();
      logic [35:0] o;
      logic v1, v2;
      fld_t e0, e1;
      e0 = '{1'b1, 2'b01, 4'd0, 2'd0, 3'b000, 6'd0};
      e1 = '{1'b1, 2'b01, 4'd0, 2'd1, 3'b000, 6'd1};
      run_pair(16'hB8C0, o, v1, v2);
      checks++; if (v2 !== 1'b1 || o !== pack2(e0, e1)) begin errors++; $display("FAIL negatives: got %h/%b expected %h/1", o, v2, pack2(e0, e1)); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [6];
      logic [35:0] expq [$];
      logic [35:0] held;
      logic [35:0] e;
      bit          held_v;
      int          sent, got, cyc;
      words = '{16'h5240, 16'h017F, 16'h8000, 16'hB8C0, 16'h3A6D, 16'hF112};
      held = '0; held_v = 1'b0; sent = 0; got = 0; cyc = 0;
      while (got < 6 && cyc < 60) begin
         in_valid  = (sent < 6);
         in_data   = (sent < 6) ? words[sent] : 16'h0;
         out_ready = (cyc >= 4);
         @(negedge clk);
         if (cyc == 2) begin
            checks++; if (in_ready !== 1'b0 || sent != 2) begin errors++; $display("FAIL bp_stall: in_ready %b accepted %0d, expected 0 and 2", in_ready, sent); end
         end
         if (held_v) begin
            checks++; if (outs !== held) begin errors++; $display("FAIL bp_hold: got %h expected %h", outs, held); end
         end
         held_v = out_valid && !out_ready;
         held   = outs;
         if (out_valid && out_ready) begin
            checks++;
            if (expq.size() == 0) begin errors++; $display("FAIL bp_extra: unexpected output %h", outs); end
            else begin
               e = expq.pop_front();
               if (outs !== e) begin errors++; $display("FAIL bp_order: got %h expected %h", outs, e); end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(model2(in_data));
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != 6 || expq.size() != 0) begin errors++; $display("FAIL bp_count: got %0d outputs, %0d pending, expected 6 and 0", got, expq.size()); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      bit seen;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h5240;
      @(posedge clk); #1;
      in_data = 16'h017F;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_prefill: ready %b valid %b expected 0 1", in_ready, out_valid); end
      flush = 1'b1; in_valid = 1'b1; in_data = 16'hB8C0; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: out_valid got %b expected 0", out_valid); end
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL flush_drop: same-cycle input emerged, got 1 expected 0"); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h5240;
      @(posedge clk); #1;
      in_data = 16'h017F;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_during: ready %b valid %b expected 0 0", in_ready, out_valid); end
      @(posedge clk); #1;
      checks++; if (outs !== 36'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_clear: data %h valid %b expected 0 0", outs, out_valid); end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_after: in_ready got %b expected 1", in_ready); end
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL rst_leak: stale output emerged, got 1 expected 0"); end
   endtask

   task automatic test_sweep();
      logic [35:0] expq [$];
      logic [35:0] e;
      int          sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      while (got < 256 && cyc < 5000) begin
         in_valid  = (sent < 256) && ($urandom_range(0, 3) != 0);
         in_data   = {8'(sent * 37 + 11), 8'(sent)};
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++;
            if (expq.size() == 0) begin errors++; $display("FAIL sweep_extra: unexpected output %h", outs); end
            else begin
               e = expq.pop_front();
               if (outs !== e) begin errors++; $display("FAIL sweep_%0d: got %h expected %h", got, outs, e); end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(model2(in_data));
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != 256) begin errors++; $display("FAIL sweep_count: got %0d outputs expected 256", got); end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      test_reset();
      test_basic();
      test_extremes();
      test_negatives();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
